// File: rtl/ddr_wr_burst_serdes.sv
// DDR write-path burst serializer: takes one whole burst per handshake and emits
// rise/fall beat pairs for DQ/DM plus DQS preamble/postamble and output enables.
module ddr_wr_burst_serdes #(
  parameter int LANES     = 16,
  parameter int BURST_LEN = 8,
  parameter int CHOP_EN   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LANES*BURST_LEN-1:0]      in_data,
  input  logic [(LANES/8)*BURST_LEN-1:0]  in_mask,
  input  logic                            in_chop,
  output logic [LANES-1:0]                dq_rise,
  output logic [LANES-1:0]                dq_fall,
  output logic [LANES/8-1:0]              dm_rise,
  output logic [LANES/8-1:0]              dm_fall,
  output logic                            dq_oe,
  output logic                            dqs_rise,
  output logic                            dqs_fall,
  output logic                            dqs_oe,
  output logic                            busy,
  output logic                            burst_done
);

  localparam int BL = LANES / 8;
  localparam int DW = LANES * BURST_LEN;
  localparam int MW = BL * BURST_LEN;
  localparam int CW = (BURST_LEN / 2 > 1) ? $clog2(BURST_LEN / 2) : 1;
  localparam logic [CW-1:0] LAST_FULL = CW'(BURST_LEN / 2 - 1);
  localparam logic [CW-1:0] LAST_CHOP = CW'(1);
  localparam bit CHOP_OK = (CHOP_EN != 0) && (BURST_LEN == 8);

  typedef enum logic [1:0] {IDLE, PRE, DATA, POST} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] dsr, dsr_nxt, dsrc;
  logic [MW-1:0] msr, msr_nxt, msrc;
  logic          chop_q, chop_nxt;
  logic          accept, last_data;

  logic [LANES-1:0] dq_rise_d, dq_fall_d;
  logic [BL-1:0]    dm_rise_d, dm_fall_d;
  logic             dq_oe_d, dqs_rise_d, dqs_fall_d, dqs_oe_d;
  logic             busy_d, done_d, rdy_d;

  assign accept    = in_valid & in_ready;
  assign last_data = (state == DATA) && (cnt == (chop_q ? LAST_CHOP : LAST_FULL));
  // A seamless accept feeds the new burst straight into the outgoing beat pair.
  assign dsrc      = accept ? in_data : dsr;
  assign msrc      = accept ? in_mask : msr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      dsr    <= '0;
      msr    <= '0;
      chop_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      dsr    <= dsr_nxt;
      msr    <= msr_nxt;
      chop_q <= chop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dsr_nxt   = dsr;
    msr_nxt   = msr;
    chop_nxt  = chop_q;
    if (accept) chop_nxt = in_chop & CHOP_OK;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = PRE;
          dsr_nxt   = in_data;
          msr_nxt   = in_mask;
        end
      end
      PRE: begin
        state_nxt = DATA;
        cnt_nxt   = '0;
        dsr_nxt   = dsrc >> (2 * LANES);
        msr_nxt   = msrc >> (2 * BL);
      end
      DATA: begin
        dsr_nxt = dsrc >> (2 * LANES);
        msr_nxt = msrc >> (2 * BL);
        if (last_data) begin
          cnt_nxt   = '0;
          state_nxt = accept ? DATA : POST;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so every port is a flop.
  always_comb begin
    dq_rise_d  = '0;
    dq_fall_d  = '0;
    dm_rise_d  = '0;
    dm_fall_d  = '0;
    dq_oe_d    = 1'b0;
    dqs_rise_d = 1'b0;
    dqs_fall_d = 1'b0;
    dqs_oe_d   = 1'b0;
    done_d     = 1'b0;
    rdy_d      = 1'b0;
    busy_d     = (state_nxt != IDLE);
    case (state_nxt)
      IDLE: rdy_d = 1'b1;
      PRE:  dqs_oe_d = 1'b1;
      DATA: begin
        dq_oe_d    = 1'b1;
        dqs_oe_d   = 1'b1;
        dqs_rise_d = 1'b1;
        dq_rise_d  = dsrc[LANES-1:0];
        dq_fall_d  = dsrc[2*LANES-1:LANES];
        dm_rise_d  = msrc[BL-1:0];
        dm_fall_d  = msrc[2*BL-1:BL];
        done_d     = (cnt_nxt == (chop_nxt ? LAST_CHOP : LAST_FULL));
        rdy_d      = done_d;
      end
      default: dqs_oe_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dq_rise    <= '0;
      dq_fall    <= '0;
      dm_rise    <= '0;
      dm_fall    <= '0;
      dq_oe      <= 1'b0;
      dqs_rise   <= 1'b0;
      dqs_fall   <= 1'b0;
      dqs_oe     <= 1'b0;
      busy       <= 1'b0;
      burst_done <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      dq_rise    <= dq_rise_d;
      dq_fall    <= dq_fall_d;
      dm_rise    <= dm_rise_d;
      dm_fall    <= dm_fall_d;
      dq_oe      <= dq_oe_d;
      dqs_rise   <= dqs_rise_d;
      dqs_fall   <= dqs_fall_d;
      dqs_oe     <= dqs_oe_d;
      busy       <= busy_d;
      burst_done <= done_d;
      in_ready   <= rdy_d;
    end
  end

endmodule

// File: tb/tb_ddr_wr_burst_serdes.sv
// Bench for ddr_wr_burst_serdes: a cycle-indexed schedule of expected outputs is built
// from each accepted burst and compared every cycle, plus literal directed checks.
module tb_ddr_wr_burst_serdes;
  localparam int N = 8192;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_chop = 1'b0;
  logic [127:0] in_data = '0;
  logic [15:0]  in_mask = '0;
  logic         in_ready, dq_oe, dqs_rise, dqs_fall, dqs_oe, busy, burst_done;
  logic [15:0]  dq_rise, dq_fall;
  logic [1:0]   dm_rise, dm_fall;

  ddr_wr_burst_serdes #(.LANES(16), .BURST_LEN(8), .CHOP_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mask(in_mask), .in_chop(in_chop),
    .dq_rise(dq_rise), .dq_fall(dq_fall), .dm_rise(dm_rise), .dm_fall(dm_fall),
    .dq_oe(dq_oe), .dqs_rise(dqs_rise), .dqs_fall(dqs_fall), .dqs_oe(dqs_oe),
    .busy(busy), .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  // Expected behaviour per cycle: kind 0=idle 1=preamble 2=data 3=postamble.
  int        kind [N];
  bit [15:0] er [N];
  bit [15:0] ef [N];
  bit [1:0]  mr [N];
  bit [1:0]  mf [N];
  bit        dn [N];
  int        cyc = 0;
  bit        chk_en = 1'b0;
  int        pass_cnt = 0;
  int        tot_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic bit ready_of(input int c);
    return (kind[c] == 0) || (kind[c] == 2 && dn[c]);
  endfunction

  task automatic schedule(input int c, input logic [127:0] d, input logic [15:0] m, input logic ch);
    int nb = ch ? 2 : 4;
    int s;
    if (kind[c] == 2) s = c + 1;
    else begin
      kind[c+1] = 1; er[c+1] = 0; ef[c+1] = 0; mr[c+1] = 0; mf[c+1] = 0; dn[c+1] = 0;
      s = c + 2;
    end
    for (int k = 0; k < nb; k++) begin
      kind[s+k] = 2;
      er[s+k]   = d[32*k +: 16];
      ef[s+k]   = d[32*k+16 +: 16];
      mr[s+k]   = m[4*k +: 2];
      mf[s+k]   = m[4*k+2 +: 2];
      dn[s+k]   = (k == nb - 1);
    end
    kind[s+nb] = 3; er[s+nb] = 0; ef[s+nb] = 0; mr[s+nb] = 0; mf[s+nb] = 0; dn[s+nb] = 0;
  endtask

  task automatic clear_model(input int from);
    for (int i = from; i < N; i++) begin
      kind[i] = 0; er[i] = 0; ef[i] = 0; mr[i] = 0; mf[i] = 0; dn[i] = 0;
    end
  endtask

  always @(posedge clk) begin
    if (rst && in_valid && ready_of(cyc)) schedule(cyc, in_data, in_mask, in_chop);
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk($sformatf("cyc%0d_data", cyc), 64'({dq_rise, dq_fall, dm_rise, dm_fall}),
          64'({er[cyc], ef[cyc], mr[cyc], mf[cyc]}));
      chk($sformatf("cyc%0d_ctrl", cyc),
          64'({in_ready, busy, burst_done, dq_oe, dqs_oe, dqs_rise, dqs_fall}),
          64'({ready_of(cyc), kind[cyc] != 0, kind[cyc] == 2 && dn[cyc], kind[cyc] == 2,
               kind[cyc] != 0, kind[cyc] == 2, 1'b0}));
    end
  end

  // Returns at the negedge of the cycle after the accepting edge.
  task automatic send(input logic [127:0] d, input logic [15:0] m, input logic ch, output int acc_cyc);
    bit acc = 1'b0;
    acc_cyc = -1;
    in_data = d; in_mask = m; in_chop = ch; in_valid = 1'b1;
    for (int t = 0; t < 40 && !acc; t++) begin
      acc = ready_of(cyc);
      acc_cyc = cyc;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("reset_outputs", 64'({in_ready, busy, burst_done, dq_oe, dqs_oe, dqs_rise, dqs_fall,
                              dq_rise, dq_fall, dm_rise, dm_fall}), 64'(0));
    clear_model(cyc);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_reset", 64'(in_ready), 64'(1));
    chk_en = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] d;
    logic [15:0]  er_lit [4];
    int a1, a2, gap;

    #1 do_reset();

    // Test-plan burst: beat b = 16'h1111*b, no mask.
    for (int b = 0; b < 8; b++) d[16*b +: 16] = 16'h1111 * b[15:0];
    er_lit = '{16'h0000, 16'h2222, 16'h4444, 16'h6666};
    send(d, 16'h0, 1'b0, a1);
    chk("pre_levels", 64'({dqs_oe, dq_oe, dqs_rise, busy}), 64'(4'b1001));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t1_rise%0d", k), 64'(dq_rise), 64'(er_lit[k]));
      chk($sformatf("t1_fall%0d", k), 64'(dq_fall), 64'(er_lit[k] + 16'h1111));
      chk($sformatf("t1_done%0d", k), 64'(burst_done), 64'(k == 3));
    end
    @(negedge clk);
    chk("t1_post", 64'({dqs_oe, dq_oe, dq_rise, busy}), 64'({1'b1, 1'b0, 16'h0, 1'b1}));
    @(negedge clk);
    chk("t1_idle", 64'({in_ready, busy, dqs_oe}), 64'(3'b100));

    // Chopped burst: beats 4..7 must never appear.
    d = {16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hA003, 16'hA002, 16'hA001, 16'hA000};
    send(d, 16'h0, 1'b1, a1);
    @(negedge clk);
    chk("chop_b01", 64'({dq_rise, dq_fall, burst_done}), 64'({16'hA000, 16'hA001, 1'b0}));
    @(negedge clk);
    chk("chop_b23", 64'({dq_rise, dq_fall, burst_done}), 64'({16'hA002, 16'hA003, 1'b1}));
    @(negedge clk);
    chk("chop_post", 64'({dq_oe, dqs_oe, dq_rise}), 64'({1'b0, 1'b1, 16'h0}));
    repeat (2) @(negedge clk);

    // Mask on beat 3, byte 1 only.
    send({4{32'h5A5A_A5A5}}, 16'h0080, 1'b0, a1);
    @(negedge clk);
    chk("mask_c0", 64'({dm_rise, dm_fall}), 64'(4'b0000));
    @(negedge clk);
    chk("mask_c1", 64'({dm_rise, dm_fall}), 64'(4'b0010));
    repeat (4) @(negedge clk);

    // Seamless back-to-back with the second request held through preamble and data.
    send({8{16'h1234}}, 16'h0, 1'b0, a1);
    send({8{16'hCAFE}}, 16'h0, 1'b0, a2);
    chk("b2b_accept_gap", 64'(a2 - a1), 64'(5));
    chk("b2b_first_new", 64'({dq_rise, dq_oe, dqs_oe}), 64'({16'hCAFE, 1'b1, 1'b1}));
    repeat (5) @(negedge clk);

    // Reset in the third data cycle of a burst.
    send({8{16'h7777}}, 16'h0, 1'b0, a1);
    repeat (3) @(negedge clk);
    #2 do_reset();
    send({8{16'h3C3C}}, 16'h0003, 1'b0, a1);
    chk("after_reset_pre", 64'({dqs_oe, dq_oe, busy}), 64'(3'b101));
    repeat (6) @(negedge clk);

    // Random bursts with random gaps; gap 0 gives seamless back-to-back.
    for (int i = 0; i < 60; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_mask = 16'($urandom());
        @(negedge clk);
      end
      send({$urandom(), $urandom(), $urandom(), $urandom()}, 16'($urandom()),
           1'($urandom_range(0, 1)), a1);
    end
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
